fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 6 +
 rtl/rr_pick.sv | 23 ++
 rtl/fifo_wr_arbiter.sv | 73 +++++++
 tb/tb_fifo_wr_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared FSM state type and default sizing for the FIFO write arbiter.
package fifo_arb_pkg;
   typedef enum logic {IDLE, BURST} state_t;
   localparam int DEF_WIDTH = 128;
   localparam int DEF_NUM_REQ = 4;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin winner selection.
// Ports: req (request vector), last (index granted last time),
//        win (first requester after last, wrapping), any (some request present).
module rr_pick #(
   parameter int N = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [IW-1:0] win,
   output logic          any
);
   // Scan from farthest to nearest so the nearest requester after last overwrites.
   always_comb begin
      win = '0;
      any = |req;
      for (int k = N; k >= 1; k--) begin
         logic [IW-1:0] c;
         c = IW'((int'(last) + k) % N);
         if (req[c]) win = c;
      end
   end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-atomic round-robin arbiter feeding one shared FIFO write port.
// Ports: clk/rst (sync active-high); req_valid/req_last/req_data/req_ready per requester;
//        fifo_full/fifo_almost_full in; fifo_write_en/fifo_data_in registered write out;
//        grant_id current or last owner; busy high while a packet is in progress.
// Option: FIFO_ARB_THROTTLE_EN also stalls on fifo_almost_full and blocks new grants then.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int WIDTH = DEF_WIDTH,
   localparam int IW = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ-1:0]       req_last,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic                     fifo_full,
   input  logic                     fifo_almost_full,
   output logic                     fifo_write_en,
   output logic [WIDTH-1:0]         fifo_data_in,
   output logic [IW-1:0]            grant_id,
   output logic                     busy
);
   state_t        state, state_n;
   logic [IW-1:0] last_grant, win;
   logic          any, stall, can_grant, grant, accept, done;
`ifdef FIFO_ARB_THROTTLE_EN
   assign stall = fifo_full || fifo_almost_full;
   assign can_grant = !fifo_almost_full;
`else
   assign stall = fifo_full;
   assign can_grant = 1'b1;
`endif
   rr_pick #(.N(NUM_REQ)) u_pick (
      .req  (req_valid),
      .last (last_grant),
      .win  (win),
      .any  (any)
   );
   assign busy = state == BURST;
   assign grant = state == IDLE && any && can_grant;
   always_comb begin
      req_ready = '0;
      if (busy && !stall) req_ready[grant_id] = 1'b1;
   end
   assign accept = req_valid[grant_id] && req_ready[grant_id];
   assign done = accept && req_last[grant_id];
   always_comb begin
      state_n = state;
      if (grant) state_n = BURST;
      if (done) state_n = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_n;
   end
   // The write is registered; the FIFO full threshold leaves a slot for this in-flight beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= IW'(NUM_REQ - 1);
         grant_id <= '0;
         fifo_write_en <= 1'b0;
         fifo_data_in <= '0;
      end else begin
         fifo_write_en <= accept;
         if (grant) grant_id <= win;
         if (done) last_grant <= grant_id;
         if (accept) fifo_data_in <= req_data[int'(grant_id)*WIDTH +: WIDTH];
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench for fifo_wr_arbiter (NUM_REQ=4, WIDTH=128).
module tb_fifo_wr_arbiter;
   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_valid, req_last, req_ready;
   logic [511:0] req_data;
   logic         fifo_full, fifo_almost_full, fifo_write_en, busy;
   logic [127:0] fifo_data_in;
   logic [1:0]   grant_id;
   int           n_cmp = 0;
   int           n_bad = 0;

   fifo_wr_arbiter dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_last         (req_last),
      .req_data         (req_data),
      .req_ready        (req_ready),
      .fifo_full        (fifo_full),
      .fifo_almost_full (fifo_almost_full),
      .fifo_write_en    (fifo_write_en),
      .fifo_data_in     (fifo_data_in),
      .grant_id         (grant_id),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input logic v, input logic l, input logic [127:0] d);
      req_valid[i] = v;
      req_last[i] = l;
      req_data[i*128 +: 128] = d;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      req_valid = '0;
      req_last = '0;
      req_data = '0;
      fifo_full = 1'b0;
      fifo_almost_full = 1'b0;
      do_reset();
      check("rst_grant", grant_id, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", req_ready, 0);
      check("rst_wen", fifo_write_en, 0);
      check("rst_data", fifo_data_in, 0);
      // single requester 1, three beats A,B,C
      drive(1, 1, 0, 128'hA);
      step();
      check("t1_grant", grant_id, 1);
      check("t1_busy", busy, 1);
      check("t1_ready", req_ready, 4'b0010);
      check("t1_wen0", fifo_write_en, 0);
      step();
      check("t1_wenA", fifo_write_en, 1);
      check("t1_dA", fifo_data_in, 128'hA);
      drive(1, 1, 0, 128'hB);
      step();
      check("t1_wenB", fifo_write_en, 1);
      check("t1_dB", fifo_data_in, 128'hB);
      drive(1, 1, 1, 128'hC);
      step();
      check("t1_wenC", fifo_write_en, 1);
      check("t1_dC", fifo_data_in, 128'hC);
      check("t1_idle", busy, 0);
      drive(1, 0, 0, 128'h0);
      step();
      check("t1_wen_off", fifo_write_en, 0);
      check("t1_hold", fifo_data_in, 128'hC);
      // all four request single-beat packets from reset: order 0,1,2,3,0
      rst = 1'b1;
      step();
      for (int i = 0; i < 4; i++) drive(i, 1, 1, 128'h100 + 128'(i));
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("t2_grant%0d", k), grant_id, 128'(k % 4));
         check($sformatf("t2_busy%0d", k), busy, 1);
         step();
         check($sformatf("t2_wen%0d", k), fifo_write_en, 1);
         check($sformatf("t2_data%0d", k), fifo_data_in, 128'h100 + 128'(k % 4));
      end
      req_valid = '0;
      req_last = '0;
      // fifo_full stalls requester 2 mid-packet for 2 cycles
      drive(2, 1, 0, 128'h20);
      step();
      check("t3_grant", grant_id, 2);
      step();
      check("t3_d0", fifo_data_in, 128'h20);
      drive(2, 1, 0, 128'h21);
      fifo_full = 1'b1;
      #1;
      check("t3_ready_full", req_ready, 0);
      step();
      check("t3_wen_stall1", fifo_write_en, 0);
      check("t3_hold", fifo_data_in, 128'h20);
      check("t3_ready_full2", req_ready, 0);
      step();
      check("t3_wen_stall2", fifo_write_en, 0);
      fifo_full = 1'b0;
      #1;
      check("t3_ready_back", req_ready, 4'b0100);
      step();
      check("t3_wen1", fifo_write_en, 1);
      check("t3_d1", fifo_data_in, 128'h21);
      drive(2, 1, 1, 128'h22);
      step();
      check("t3_d2", fifo_data_in, 128'h22);
      check("t3_idle", busy, 0);
      drive(2, 0, 0, 128'h0);
      // owner 3 bubbles 3 cycles while requester 2 waits
      drive(3, 1, 0, 128'h30);
      drive(2, 1, 1, 128'h2F);
      step();
      check("t4_grant", grant_id, 3);
      step();
      check("t4_d0", fifo_data_in, 128'h30);
      drive(3, 0, 0, 128'h0);
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("t4_bub_wen%0d", k), fifo_write_en, 0);
         check($sformatf("t4_bub_grant%0d", k), grant_id, 3);
         check($sformatf("t4_bub_ready%0d", k), req_ready, 4'b1000);
      end
      drive(3, 1, 1, 128'h31);
      step();
      check("t4_d1", fifo_data_in, 128'h31);
      check("t4_idle", busy, 0);
      drive(3, 0, 0, 128'h0);
      step();
      check("t4_grant2", grant_id, 2);
      step();
      check("t4_d2", fifo_data_in, 128'h2F);
      drive(2, 0, 0, 128'h0);
      // reset mid-burst
      drive(1, 1, 0, 128'h40);
      step();
      check("t5_grant", grant_id, 1);
      step();
      check("t5_d0", fifo_data_in, 128'h40);
      rst = 1'b1;
      step();
      check("t5_busy", busy, 0);
      check("t5_ready", req_ready, 0);
      check("t5_wen", fifo_write_en, 0);
      check("t5_gid", grant_id, 0);
      check("t5_data", fifo_data_in, 0);
      rst = 1'b0;
      drive(0, 1, 1, 128'h50);
      step();
      check("t5_grant0", grant_id, 0);
      check("t5_wen_after", fifo_write_en, 0);
      step();
      check("t5_d50", fifo_data_in, 128'h50);
      req_valid = '0;
      req_last = '0;
      // almost-full behaviour
      fifo_almost_full = 1'b1;
      drive(1, 1, 1, 128'h60);
`ifdef FIFO_ARB_THROTTLE_EN
      step();
      check("t6_no_grant", busy, 0);
      step();
      check("t6_no_grant2", busy, 0);
      fifo_almost_full = 1'b0;
      step();
      check("t6_grant", grant_id, 1);
      fifo_almost_full = 1'b1;
      #1;
      check("t6_ready_af", req_ready, 0);
      step();
      check("t6_wen_af", fifo_write_en, 0);
      fifo_almost_full = 1'b0;
      step();
      check("t6_d", fifo_data_in, 128'h60);
`else
      step();
      check("t6_grant", grant_id, 1);
      check("t6_ready_af", req_ready, 4'b0010);
      step();
      check("t6_wen", fifo_write_en, 1);
      check("t6_d", fifo_data_in, 128'h60);
`endif
      req_valid = '0;
      fifo_almost_full = 1'b0;
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
